// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the instruction-fetch and data-access ports.
// Grants are serialised by a small FSM; DM has priority unless fetch has waited too long.
module mem_port_arbiter #(
   parameter int unsigned MAX_DM_STREAK = 4,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   // Instruction-fetch port
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic [31:0] o_if_rdata,
   output logic        o_if_ready,
   // Data-access port
   input  logic        i_dm_req,
   input  logic        i_dm_we,
   input  logic [3:0]  i_dm_wea,
   input  logic [31:0] i_dm_addr,
   input  logic [31:0] i_dm_wdata,
   output logic [31:0] o_dm_rdata,
   output logic        o_dm_ready,
   // Unified memory
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_wea,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ready,
   // Core status
   output logic        o_cpu_stall,
   output logic        o_bus_err
);

   localparam logic [3:0] StreakMax = 4'(MAX_DM_STREAK);
   localparam logic [7:0] TmoLast   = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIfBusy = 2'd1,
      StDmBusy = 2'd2
   } state_e;

   state_e      r_state;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [3:0]  r_mem_wea;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_bus_err;
   logic [3:0]  r_streak;
   logic [7:0]  r_tmo;

   logic        w_busy;
   logic        w_timeout;
   logic        w_done;
   logic        w_grant_dm;
   logic        w_grant_if;
   logic [31:0] w_rdata;

   always_comb begin
      w_busy     = (r_state != StIdle);
      // Abort in the busy cycle that would bring the idle count up to TIMEOUT.
      w_timeout  = w_busy & ~i_mem_ready & (r_tmo == TmoLast);
      w_done     = w_busy & (i_mem_ready | w_timeout);
      w_grant_dm = i_dm_req & (~i_if_req | (r_streak < StreakMax));
      w_grant_if = ~w_grant_dm & i_if_req;
      w_rdata    = w_timeout ? 32'h0 : i_mem_rdata;
   end

   always_comb begin
      o_if_ready  = (r_state == StIfBusy) & w_done;
      o_dm_ready  = (r_state == StDmBusy) & w_done;
      o_if_rdata  = w_rdata;
      o_dm_rdata  = w_rdata;
      o_cpu_stall = (i_if_req & ~o_if_ready) | (i_dm_req & ~o_dm_ready);
      o_mem_req   = r_mem_req;
      o_mem_we    = r_mem_we;
      o_mem_wea   = r_mem_wea;
      o_mem_addr  = r_mem_addr;
      o_mem_wdata = r_mem_wdata;
      o_bus_err   = r_bus_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wea   <= 4'h0;
         r_mem_addr  <= 32'h0;
         r_mem_wdata <= 32'h0;
         r_bus_err   <= 1'b0;
         r_streak    <= 4'h0;
         r_tmo       <= 8'h0;
      end else begin
         case (r_state)
            StIdle: begin
               if (!i_if_req) begin
                  r_streak <= 4'h0;
               end
               if (w_grant_dm) begin
                  r_state     <= StDmBusy;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= i_dm_we;
                  r_mem_wea   <= i_dm_we ? i_dm_wea : 4'h0;
                  r_mem_addr  <= i_dm_addr;
                  r_mem_wdata <= i_dm_wdata;
                  r_tmo       <= 8'h0;
                  if (i_if_req && (r_streak != StreakMax)) begin
                     r_streak <= r_streak + 4'd1;
                  end
               end else if (w_grant_if) begin
                  r_state     <= StIfBusy;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_wea   <= 4'h0;
                  r_mem_addr  <= i_if_addr;
                  r_mem_wdata <= 32'h0;
                  r_tmo       <= 8'h0;
                  r_streak    <= 4'h0;
               end
            end
            StIfBusy, StDmBusy: begin
               if (w_done) begin
                  r_state   <= StIdle;
                  r_mem_req <= 1'b0;
                  if (w_timeout) begin
                     r_bus_err <= 1'b1;
                  end
               end else begin
                  r_tmo <= r_tmo + 8'd1;
               end
            end
            default: begin
               r_state   <= StIdle;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   a_ready_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(o_if_ready && o_dm_ready));

   a_req_in_busy : assert property (@(posedge clk) disable iff (!rst_n)
      (r_state != StIdle) |-> r_mem_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_DM_STREAK=4, TIMEOUT=16).
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic [31:0] o_if_rdata;
   logic        o_if_ready;
   logic        i_dm_req;
   logic        i_dm_we;
   logic [3:0]  i_dm_wea;
   logic [31:0] i_dm_addr;
   logic [31:0] i_dm_wdata;
   logic [31:0] o_dm_rdata;
   logic        o_dm_ready;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [3:0]  o_mem_wea;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;
   logic        i_mem_ready;
   logic        o_cpu_stall;
   logic        o_bus_err;

   int n_checks;
   int n_errors;

   mem_port_arbiter #(
      .MAX_DM_STREAK(4),
      .TIMEOUT      (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_if_req   (i_if_req),
      .i_if_addr  (i_if_addr),
      .o_if_rdata (o_if_rdata),
      .o_if_ready (o_if_ready),
      .i_dm_req   (i_dm_req),
      .i_dm_we    (i_dm_we),
      .i_dm_wea   (i_dm_wea),
      .i_dm_addr  (i_dm_addr),
      .i_dm_wdata (i_dm_wdata),
      .o_dm_rdata (o_dm_rdata),
      .o_dm_ready (o_dm_ready),
      .o_mem_req  (o_mem_req),
      .o_mem_we   (o_mem_we),
      .o_mem_wea  (o_mem_wea),
      .o_mem_addr (o_mem_addr),
      .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata),
      .i_mem_ready(i_mem_ready),
      .o_cpu_stall(o_cpu_stall),
      .o_bus_err  (o_bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      i_if_req    = 1'b0;
      i_if_addr   = 32'h0;
      i_dm_req    = 1'b0;
      i_dm_we     = 1'b0;
      i_dm_wea    = 4'h0;
      i_dm_addr   = 32'h0;
      i_dm_wdata  = 32'h0;
      i_mem_rdata = 32'h0;
      i_mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic exp_stall;
      #2 rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         i_if_req    = 1'($urandom);
         i_if_addr   = $urandom;
         i_dm_req    = 1'($urandom);
         i_dm_we     = 1'($urandom);
         i_dm_wea    = 4'($urandom);
         i_dm_addr   = $urandom;
         i_dm_wdata  = $urandom;
         i_mem_rdata = $urandom;
         i_mem_ready = 1'($urandom);
         exp_stall   = i_if_req | i_dm_req;
         mid();
         n_checks++;
         if ({o_mem_req, o_mem_we, o_mem_wea, o_mem_addr, o_mem_wdata} !== 70'h0) begin
            n_errors++;
            $display("FAIL reset_mem: got req=%b we=%b wea=%h addr=%h wdata=%h expected all 0",
                     o_mem_req, o_mem_we, o_mem_wea, o_mem_addr, o_mem_wdata);
         end
         n_checks++;
         if ({o_if_ready, o_dm_ready, o_bus_err} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags: got if_ready=%b dm_ready=%b bus_err=%b expected 000",
                     o_if_ready, o_dm_ready, o_bus_err);
         end
         n_checks++;
         if (o_cpu_stall !== exp_stall) begin
            n_errors++;
            $display("FAIL reset_stall: got %b expected %b", o_cpu_stall, exp_stall);
         end
      end
      clear_inputs();
      #2 rst_n = 1'b1;
      step();
      step();
   endtask

   task automatic test_single_fetch();
      step();
      i_if_req    = 1'b1;
      i_if_addr   = 32'h100;
      i_mem_ready = 1'b1;
      i_mem_rdata = 32'h0000_0013;
      mid();
      n_checks++;
      if (o_mem_req !== 1'b0 || o_cpu_stall !== 1'b1) begin
         n_errors++;
         $display("FAIL fetch_c0: got mem_req=%b stall=%b expected 0 1", o_mem_req, o_cpu_stall);
      end
      step();
      mid();
      n_checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_we !== 1'b0) begin
         n_errors++;
         $display("FAIL fetch_mem: got req=%b addr=%h we=%b expected 1 00000100 0",
                  o_mem_req, o_mem_addr, o_mem_we);
      end
      n_checks++;
      if (o_if_ready !== 1'b1 || o_if_rdata !== 32'h0000_0013 || o_dm_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL fetch_ready: got if_ready=%b rdata=%h dm_ready=%b expected 1 00000013 0",
                  o_if_ready, o_if_rdata, o_dm_ready);
      end
      step();
      i_if_req = 1'b0;
      mid();
      n_checks++;
      if (o_mem_req !== 1'b0 || o_if_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL fetch_done: got mem_req=%b if_ready=%b expected 0 0",
                  o_mem_req, o_if_ready);
      end
   endtask

   task automatic test_conflict();
      step();
      i_if_req    = 1'b1;
      i_if_addr   = 32'h104;
      i_dm_req    = 1'b1;
      i_dm_we     = 1'b1;
      i_dm_wea    = 4'hF;
      i_dm_addr   = 32'h200;
      i_dm_wdata  = 32'hDEAD_BEEF;
      i_mem_ready = 1'b1;
      i_mem_rdata = 32'h0;
      mid();
      n_checks++;
      if (o_cpu_stall !== 1'b1 || o_mem_req !== 1'b0) begin
         n_errors++;
         $display("FAIL conflict_c0: got stall=%b mem_req=%b expected 1 0", o_cpu_stall, o_mem_req);
      end
      step();
      mid();
      n_checks++;
      if (o_dm_ready !== 1'b1 || o_if_ready !== 1'b0 || o_cpu_stall !== 1'b1) begin
         n_errors++;
         $display("FAIL conflict_c1: got dm_ready=%b if_ready=%b stall=%b expected 1 0 1",
                  o_dm_ready, o_if_ready, o_cpu_stall);
      end
      n_checks++;
      if (o_mem_we !== 1'b1 || o_mem_wea !== 4'hF || o_mem_addr !== 32'h200 ||
          o_mem_wdata !== 32'hDEAD_BEEF) begin
         n_errors++;
         $display("FAIL conflict_write: got we=%b wea=%h addr=%h wdata=%h expected 1 f 00000200 deadbeef",
                  o_mem_we, o_mem_wea, o_mem_addr, o_mem_wdata);
      end
      step();
      i_dm_req = 1'b0;
      mid();
      n_checks++;
      if (o_cpu_stall !== 1'b1 || o_mem_req !== 1'b0 || o_if_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL conflict_c2: got stall=%b mem_req=%b if_ready=%b expected 1 0 0",
                  o_cpu_stall, o_mem_req, o_if_ready);
      end
      step();
      mid();
      n_checks++;
      if (o_if_ready !== 1'b1 || o_mem_addr !== 32'h104 || o_mem_we !== 1'b0 ||
          o_mem_wea !== 4'h0 || o_cpu_stall !== 1'b0) begin
         n_errors++;
         $display("FAIL conflict_c3: got if_ready=%b addr=%h we=%b wea=%h stall=%b expected 1 00000104 0 0 0",
                  o_if_ready, o_mem_addr, o_mem_we, o_mem_wea, o_cpu_stall);
      end
      step();
      i_if_req = 1'b0;
      mid();
   endtask

   task automatic test_starvation();
      logic exp_dm [10];
      int   k;
      exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      k = 0;
      step();
      i_if_req    = 1'b1;
      i_if_addr   = 32'h500;
      i_dm_req    = 1'b1;
      i_dm_we     = 1'b0;
      i_dm_addr   = 32'h400;
      i_mem_ready = 1'b1;
      i_mem_rdata = 32'h0000_A5A5;
      mid();
      for (int c = 0; c < 40 && k < 10; c++) begin
         step();
         mid();
         if (o_if_ready === 1'b1 || o_dm_ready === 1'b1) begin
            n_checks++;
            if (o_dm_ready !== exp_dm[k] || o_if_ready !== !exp_dm[k]) begin
               n_errors++;
               $display("FAIL starve_grant%0d: got dm_ready=%b if_ready=%b expected dm_ready=%b",
                        k, o_dm_ready, o_if_ready, exp_dm[k]);
            end
            k++;
         end
      end
      n_checks++;
      if (k !== 10) begin
         n_errors++;
         $display("FAIL starve_count: got %0d accesses expected 10", k);
      end
      step();
      i_if_req = 1'b0;
      i_dm_req = 1'b0;
      mid();
      step();
      mid();
   endtask

   task automatic test_timeout();
      int early;
      int unstable;
      early    = 0;
      unstable = 0;
      step();
      i_mem_ready = 1'b0;
      i_mem_rdata = 32'hFFFF_FFFF;
      i_dm_req    = 1'b1;
      i_dm_we     = 1'b0;
      i_dm_wea    = 4'hF;
      i_dm_addr   = 32'h300;
      mid();
      for (int c = 1; c <= 15; c++) begin
         step();
         mid();
         if (o_dm_ready === 1'b1 || o_if_ready === 1'b1) early++;
         if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h300) unstable++;
      end
      n_checks++;
      if (early !== 0) begin
         n_errors++;
         $display("FAIL tmo_early: got %0d ready pulses before cycle 16 expected 0", early);
      end
      n_checks++;
      if (unstable !== 0 || o_mem_wea !== 4'h0) begin
         n_errors++;
         $display("FAIL tmo_stable: got %0d unstable cycles wea=%h expected 0 0", unstable, o_mem_wea);
      end
      step();
      mid();
      n_checks++;
      if (o_dm_ready !== 1'b1 || o_dm_rdata !== 32'h0 || o_bus_err !== 1'b0) begin
         n_errors++;
         $display("FAIL tmo_pulse: got dm_ready=%b rdata=%h bus_err=%b expected 1 00000000 0",
                  o_dm_ready, o_dm_rdata, o_bus_err);
      end
      step();
      i_dm_req = 1'b0;
      mid();
      n_checks++;
      if (o_bus_err !== 1'b1 || o_mem_req !== 1'b0 || o_dm_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL tmo_after: got bus_err=%b mem_req=%b dm_ready=%b expected 1 0 0",
                  o_bus_err, o_mem_req, o_dm_ready);
      end
      step();
      i_mem_ready = 1'b1;
      i_mem_rdata = 32'hCAFE_0001;
      i_if_req    = 1'b1;
      i_if_addr   = 32'h600;
      mid();
      step();
      mid();
      n_checks++;
      if (o_if_ready !== 1'b1 || o_if_rdata !== 32'hCAFE_0001 || o_bus_err !== 1'b1) begin
         n_errors++;
         $display("FAIL tmo_next: got if_ready=%b rdata=%h bus_err=%b expected 1 cafe0001 1",
                  o_if_ready, o_if_rdata, o_bus_err);
      end
      step();
      i_if_req = 1'b0;
      mid();
   endtask

   task automatic test_reset_midop();
      step();
      i_mem_ready = 1'b0;
      i_dm_req    = 1'b1;
      i_dm_we     = 1'b1;
      i_dm_wea    = 4'h3;
      i_dm_addr   = 32'h700;
      i_dm_wdata  = 32'h1122_3344;
      mid();
      step();
      mid();
      n_checks++;
      if (o_mem_req !== 1'b1 || o_mem_wea !== 4'h3) begin
         n_errors++;
         $display("FAIL rstmid_busy: got mem_req=%b wea=%h expected 1 3", o_mem_req, o_mem_wea);
      end
      step();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (o_mem_req !== 1'b0 || o_dm_ready !== 1'b0 || o_bus_err !== 1'b0 || o_mem_addr !== 32'h0) begin
         n_errors++;
         $display("FAIL rstmid_async: got mem_req=%b dm_ready=%b bus_err=%b addr=%h expected 0 0 0 0",
                  o_mem_req, o_dm_ready, o_bus_err, o_mem_addr);
      end
      i_dm_req = 1'b0;
      mid();
      step();
      mid();
      n_checks++;
      if (o_dm_ready !== 1'b0 || o_mem_req !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_hold: got dm_ready=%b mem_req=%b expected 0 0", o_dm_ready, o_mem_req);
      end
      #2 rst_n = 1'b1;
      step();
      i_dm_req    = 1'b1;
      i_dm_we     = 1'b0;
      i_dm_addr   = 32'h704;
      i_mem_ready = 1'b1;
      i_mem_rdata = 32'h1234_5678;
      mid();
      n_checks++;
      if (o_mem_req !== 1'b0 || o_dm_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_idle: got mem_req=%b dm_ready=%b expected 0 0", o_mem_req, o_dm_ready);
      end
      step();
      mid();
      n_checks++;
      if (o_dm_ready !== 1'b1 || o_dm_rdata !== 32'h1234_5678 || o_mem_addr !== 32'h704 ||
          o_mem_we !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_serve: got dm_ready=%b rdata=%h addr=%h we=%b expected 1 12345678 00000704 0",
                  o_dm_ready, o_dm_rdata, o_mem_addr, o_mem_we);
      end
      step();
      i_dm_req = 1'b0;
      mid();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b1;
      clear_inputs();
      test_reset();
      test_single_fetch();
      test_conflict();
      test_starvation();
      test_timeout();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
